// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM; pulse widths change only at frame boundaries.
// Build option: define SERVO_RAMP_EN to slew each channel by at most STEP per frame.
module servo_pwm_array #(
  parameter int CHANNELS    = 4,
  parameter int CW          = 20,
  parameter int PERIOD      = 1000000,
  parameter int POS_MIN     = 50000,
  parameter int POS_MAX     = 100000,
  parameter int POS_NEUTRAL = 75000,
  parameter int DELTA       = 526,
  parameter int STEP        = 2000,
  parameter int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                SCLK,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHAN_W-1:0]   cmd_chan,
  input  logic [1:0]          cmd_op,
  input  logic [CW-1:0]       cmd_pos,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] busy,
  output logic                frame_start,
  output logic                cmd_err
);

  typedef enum logic [1:0] {
    OP_ABS     = 2'b00,
    OP_LEFT    = 2'b01,
    OP_RIGHT   = 2'b10,
    OP_NEUTRAL = 2'b11
  } op_e;

  localparam logic [CW:0] MIN_W   = (CW+1)'(POS_MIN);
  localparam logic [CW:0] MAX_W   = (CW+1)'(POS_MAX);
  localparam logic [CW:0] NEUT_W  = (CW+1)'(POS_NEUTRAL);
  localparam logic [CW:0] DELTA_W = (CW+1)'(DELTA);
`ifdef SERVO_RAMP_EN
  localparam logic [CW:0] STEP_W  = (CW+1)'(STEP);
`else
  // A limit wider than any reachable difference turns each boundary into a step change.
  localparam int          RAMP_LIM = (STEP > PERIOD && STEP <= 2**CW) ? STEP : PERIOD;
  localparam logic [CW:0] STEP_W   = (CW+1)'(RAMP_LIM);
`endif

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       tgt_q [CHANNELS];
  logic [CW-1:0]       tgt_d [CHANNELS];
  logic [CW-1:0]       cur_q [CHANNELS];
  logic [CW-1:0]       cur_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d, busy_q, busy_d;
  logic                frame_start_q, frame_start_d, cmd_err_q, cmd_err_d;
  logic                boundary, accept, chan_bad;

  // Target arithmetic is one bit wider so +/-DELTA can never wrap before clamping.
  function automatic logic [CW-1:0] next_target(input logic [CW-1:0] tgt, input op_e op,
                                                input logic [CW-1:0] pos);
    logic [CW:0] t, p, r;
    t = {1'b0, tgt};
    p = {1'b0, pos};
    r = t;
    unique case (op)
      OP_ABS:   r = (p < MIN_W) ? MIN_W : ((p > MAX_W) ? MAX_W : p);
      OP_LEFT:  r = (t < MIN_W + DELTA_W) ? MIN_W : t - DELTA_W;
      OP_RIGHT: r = (t + DELTA_W > MAX_W) ? MAX_W : t + DELTA_W;
      default:  r = NEUT_W;
    endcase
    return r[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] ramp(input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
    logic [CW:0] c, t, r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    r = c;
    if (t > c)      r = (t - c > STEP_W) ? c + STEP_W : t;
    else if (t < c) r = (c - t > STEP_W) ? c - STEP_W : t;
    return r[CW-1:0];
  endfunction

  assign cmd_ready = ~RESET;
  assign accept    = cmd_valid & cmd_ready;
  assign chan_bad  = (32'(cmd_chan) >= CHANNELS);
  assign boundary  = (cnt_q == CW'(PERIOD - 1));

  // NOTE: every _d signal is assigned on every path, so this block infers no latches.
  always_comb begin
    cnt_d         = boundary ? '0 : cnt_q + 1'b1;
    frame_start_d = (cnt_q == '0);
    cmd_err_d     = accept & chan_bad;
    for (int i = 0; i < CHANNELS; i++) begin
      // The boundary ramp reads tgt_q, so a command landing on that edge waits a frame.
      cur_d[i]  = boundary ? ramp(cur_q[i], tgt_q[i]) : cur_q[i];
      tgt_d[i]  = (accept && !chan_bad && cmd_chan == CHAN_W'(i))
                  ? next_target(tgt_q[i], op_e'(cmd_op), cmd_pos) : tgt_q[i];
      pwm_d[i]  = (cnt_q < cur_q[i]);
      busy_d[i] = (cur_q[i] != tgt_q[i]);
    end
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      cnt_q         <= '0;
      pwm_q         <= '0;
      busy_q        <= '0;
      frame_start_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      // NOTE: the position arrays are flops, not RAM, and must restart at neutral.
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= CW'(POS_NEUTRAL);
        cur_q[i] <= CW'(POS_NEUTRAL);
      end
    end else begin
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      cmd_err_q     <= cmd_err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

  assign pwm         = pwm_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: directed steps plus random commands against a frame-level model.
// Honours SERVO_RAMP_EN the same way the design does.
module tb_servo_pwm_array;

  localparam int CHANNELS    = 4;
  localparam int CW          = 8;
  localparam int PERIOD      = 100;
  localparam int POS_MIN     = 10;
  localparam int POS_MAX     = 90;
  localparam int POS_NEUTRAL = 50;
  localparam int DELTA       = 5;
  localparam int STEP        = 8;
  localparam int CHAN_W      = 3;

  logic                SCLK      = 1'b0;
  logic                RESET     = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [CHAN_W-1:0]   cmd_chan  = '0;
  logic [1:0]          cmd_op    = '0;
  logic [CW-1:0]       cmd_pos   = '0;
  logic [CHANNELS-1:0] pwm, busy;
  logic                frame_start, cmd_err;

  servo_pwm_array #(
    .CHANNELS(CHANNELS), .CW(CW), .PERIOD(PERIOD), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_NEUTRAL(POS_NEUTRAL), .DELTA(DELTA), .STEP(STEP), .CHAN_W(CHAN_W)
  ) dut (
    .SCLK(SCLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_op(cmd_op), .cmd_pos(cmd_pos), .pwm(pwm), .busy(busy),
    .frame_start(frame_start), .cmd_err(cmd_err)
  );

  always #5 SCLK = ~SCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_tgt [CHANNELS];
  int m_cur [CHANNELS];
  int hi [CHANNELS];
  int shape_bad [CHANNELS];
  int last_w [CHANNELS];
  int fs_bad, busy_bad, err_bad, rdy_bad;
  int ramp_exp [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_pos(input int v);
    if (v < POS_MIN) return POS_MIN;
    if (v > POS_MAX) return POS_MAX;
    return v;
  endfunction

  function automatic int apply_cmd(input int t, input int op, input int pos);
    case (op)
      0:       return clamp_pos(pos);
      1:       return clamp_pos(t - DELTA);
      2:       return clamp_pos(t + DELTA);
      default: return POS_NEUTRAL;
    endcase
  endfunction

  function automatic int move_cur(input int c, input int t);
`ifdef SERVO_RAMP_EN
    if (t > c) return c + (((t - c) < STEP) ? (t - c) : STEP);
    if (t < c) return c - (((c - t) < STEP) ? (c - t) : STEP);
    return c;
`else
    return (c == t) ? c : t;
`endif
  endfunction

  task automatic clear_accum();
    for (int i = 0; i < CHANNELS; i++) begin
      hi[i] = 0;
      shape_bad[i] = 0;
    end
    fs_bad = 0; busy_bad = 0; err_bad = 0; rdy_bad = 0;
  endtask

  // One clock edge: sample just after it and advance the model by the spec's rules.
  task automatic clk_cycle();
    bit rst_in, v;
    int ch, op, pos, p, partial;
    rst_in = RESET;
    v      = cmd_valid;
    ch     = int'(cmd_chan);
    op     = int'(cmd_op);
    pos    = int'(cmd_pos);
    @(posedge SCLK);
    #1;
    if (rst_in) begin
      partial = fs_bad + busy_bad + err_bad + rdy_bad;
      for (int i = 0; i < CHANNELS; i++) partial += shape_bad[i];
      check("partial frame before reset", partial, 0);
      check("reset pwm", pwm, 0);
      check("reset busy", busy, 0);
      check("reset frame_start", frame_start, 0);
      check("reset cmd_err", cmd_err, 0);
      check("reset cmd_ready", cmd_ready, 0);
      for (int i = 0; i < CHANNELS; i++) begin
        m_tgt[i] = POS_NEUTRAL;
        m_cur[i] = POS_NEUTRAL;
      end
      cyc = 0;
      clear_accum();
    end else begin
      cyc++;
      p = (cyc - 1) % PERIOD;
      for (int i = 0; i < CHANNELS; i++) begin
        if (pwm[i] === 1'b1) hi[i]++;
        if (pwm[i] !== (p < m_cur[i])) shape_bad[i]++;
        if (busy[i] !== (m_cur[i] != m_tgt[i])) busy_bad++;
      end
      if (frame_start !== (p == 0)) fs_bad++;
      if (cmd_err !== (v && ch >= CHANNELS)) err_bad++;
      if (cmd_ready !== 1'b1) rdy_bad++;
      if (p == PERIOD - 1) begin
        for (int i = 0; i < CHANNELS; i++) begin
          check($sformatf("width ch%0d", i), hi[i], m_cur[i]);
          check($sformatf("pulse shape errors ch%0d", i), shape_bad[i], 0);
          last_w[i] = hi[i];
        end
        check("frame_start errors", fs_bad, 0);
        check("busy errors", busy_bad, 0);
        check("cmd_err errors", err_bad, 0);
        check("cmd_ready errors", rdy_bad, 0);
        clear_accum();
        for (int i = 0; i < CHANNELS; i++) m_cur[i] = move_cur(m_cur[i], m_tgt[i]);
      end
      if (v && ch < CHANNELS) m_tgt[ch] = apply_cmd(m_tgt[ch], op, pos);
    end
  endtask

  task automatic send(input int ch, input int op, input int pos);
    cmd_valid = 1'b1;
    cmd_chan  = CHAN_W'(ch);
    cmd_op    = 2'(op);
    cmd_pos   = CW'(pos);
    clk_cycle();
    cmd_valid = 1'b0;
  endtask

  // Advance until the next edge will see the frame counter at c.
  task automatic wait_cnt(input int c);
    for (int k = 0; k < PERIOD && (cyc % PERIOD) != c; k++) clk_cycle();
  endtask

  task automatic run_to_frame_end();
    for (int k = 0; k < PERIOD; k++) begin
      clk_cycle();
      if (cyc % PERIOD == 0) break;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n) run_to_frame_end();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_accum();
    RESET = 1'b1;
    repeat (3) clk_cycle();
    RESET = 1'b0;

    // Neutral after reset
    run_frames(2);
    for (int i = 0; i < CHANNELS; i++) check($sformatf("neutral width ch%0d", i), last_w[i], 50);
    check("neutral busy", busy, 0);

    // Ramp ch1 to 90
    wait_cnt(30);
    send(1, 0, 90);
    clk_cycle();
    check("busy ch1 after command", busy[1], 1);
    run_to_frame_end();
    check("ch1 width before ramp", last_w[1], 50);
`ifdef SERVO_RAMP_EN
    ramp_exp = {58, 66, 74, 82, 90};
`else
    ramp_exp = {90};
`endif
    foreach (ramp_exp[j]) begin
      run_to_frame_end();
      check($sformatf("ramp ch1 frame %0d", j), last_w[1], ramp_exp[j]);
    end
    check("busy ch1 settled", busy[1], 0);

    // Clamping and saturation
    send(2, 0, 5);
    run_frames(7);
    check("clamp low ch2", last_w[2], 10);
    send(2, 0, 200);
    run_frames(12);
    check("clamp high ch2", last_w[2], 90);
    send(3, 0, 88);
    run_frames(7);
    check("ch3 at 88", last_w[3], 88);
    send(3, 2, 0);
    run_frames(2);
    check("step right saturates ch3", last_w[3], 90);
    for (int k = 0; k < 20; k++) send(0, 1, 0);
    run_frames(7);
    check("step left x20 saturates ch0", last_w[0], 10);

    // Command on the boundary cycle is seen one frame later
    wait_cnt(99);
    send(1, 0, 30);
    run_to_frame_end();
    check("collision: boundary ignored ch1", last_w[1], 90);
    run_to_frame_end();
`ifdef SERVO_RAMP_EN
    check("collision: following frame ch1", last_w[1], 82);
`else
    check("collision: following frame ch1", last_w[1], 30);
`endif

    // Out-of-range channel
    wait_cnt(40);
    send(5, 0, 20);
    check("cmd_err pulse", cmd_err, 1);
    clk_cycle();
    check("cmd_err one cycle", cmd_err, 0);
    run_frames(1);

    // Random commands, including bad channels and boundary hits
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        cmd_valid = 1'b1;
        cmd_chan  = CHAN_W'($urandom_range(0, 7));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_pos   = CW'($urandom_range(0, 255));
      end else begin
        cmd_valid = 1'b0;
      end
      clk_cycle();
    end
    cmd_valid = 1'b0;
    run_frames(12);

    // Reset during the ch0 high phase
    wait_cnt(6);
    check("pwm0 high before reset", pwm[0], 1);
    RESET = 1'b1;
    clk_cycle();
    check("pwm0 low after reset", pwm[0], 0);
    clk_cycle();
    RESET = 1'b0;
    run_frames(2);
    for (int i = 0; i < CHANNELS; i++) check($sformatf("restart width ch%0d", i), last_w[i], 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
